// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, interrupt-controller FSM state type and the
// priority encoder shared by the CP0 interrupt controller files.
package cp0_pkg;

  localparam logic [4:0] CP0_PEND = 5'h0d;
  localparam logic [4:0] CP0_EPC  = 5'h0e;
  localparam logic [4:0] CP0_DIS  = 5'h16;
  localparam logic [4:0] CP0_MASK = 5'h17;
  localparam logic [4:0] CP0_INSV = 5'h18;

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} cp0_state_t;

  // Index of the highest set bit; returns 0 for an empty vector, so callers
  // test for "any bit set" separately.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-line 2-flop synchroniser plus previous-value flop; emits a
// one-cycle rise pulse for each rising edge seen on the synchronised line.
module irq_sync_edge #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  output logic [N-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_line
      logic s1_reg, s2_reg, prev_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          s1_reg   <= irq_in[gi];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
        end
      end

      assign rise[gi] = s2_reg & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: N-source prioritised, vectored CP0 interrupt controller with EPC,
// disable, mask, pending (W1C) and in-service registers. Define CP0_NEST_EN for
// nested entry with an EPC stack.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          N_IRQ      = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             stall,
  input  logic [31:0]      pc_resume,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  input  logic             eret,
  output logic [31:0]      cp0_rdata,
  output logic             take_irq,
  output logic [31:0]      irq_vector,
  output logic [31:0]      epc
);

  cp0_state_t       state_reg, state_next;
  logic [N_IRQ-1:0] rise, pend_reg, mask_reg, insv_reg;
  logic [N_IRQ-1:0] elig, cand, win_onehot, pend_w1c, take_clr, insv_after_eret;
  logic             dis_reg, take_go, nest_go, eret_svc;
  logic [2:0]       win_idx;
  logic [31:0]      vec_reg, level, vec_calc;

  irq_sync_edge #(.N(N_IRQ)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .rise   (rise)
  );

  assign elig = pend_reg & mask_reg & {N_IRQ{~dis_reg}};

`ifdef CP0_NEST_EN
  logic [2:0]       top_idx;
  logic [N_IRQ-1:0] top_onehot, raw;
  assign raw     = pend_reg & mask_reg;
  assign top_idx = prio_enc(8'(insv_reg));
  // Nested entry ignores disable but must outrank the highest source in service.
  assign nest_go = (state_reg == SERVICE) && (|raw) && (prio_enc(8'(raw)) > top_idx);
  assign cand    = (state_reg == SERVICE) ? raw : elig;
  assign insv_after_eret = insv_reg & ~top_onehot;
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_top
      assign top_onehot[gi] = (top_idx == 3'(gi));
    end
  endgenerate
`else
  assign nest_go = 1'b0;
  assign cand    = elig;
  assign insv_after_eret = '0;
`endif

  assign win_idx  = prio_enc(8'(cand));
  assign take_go  = !stall && !eret && (((state_reg == IDLE) && (|elig)) || nest_go);
  assign eret_svc = eret && (state_reg == SERVICE);
  assign level    = 32'(N_IRQ - 1) - 32'(win_idx);
  assign vec_calc = VEC_BASE + level * VEC_STRIDE;
  assign pend_w1c = (cp0_we && cp0_addr == CP0_PEND) ? cp0_wdata[N_IRQ-1:0] : '0;
  assign take_clr = take_go ? win_onehot : '0;

  genvar wi;
  generate
    for (wi = 0; wi < N_IRQ; wi++) begin : g_win
      assign win_onehot[wi] = (win_idx == 3'(wi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take_go) state_next = TAKE;
      TAKE:    state_next = SERVICE;
      SERVICE: begin
        if (take_go) state_next = TAKE;
        else if (eret && insv_after_eret == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dis_reg   <= 1'b1;
      mask_reg  <= '0;
      pend_reg  <= '0;
      insv_reg  <= '0;
      vec_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // New edges win over both the take clear and a W1C in the same cycle.
      pend_reg  <= (pend_reg & ~pend_w1c & ~take_clr) | rise;
      if (cp0_we && cp0_addr == CP0_MASK) mask_reg <= cp0_wdata[N_IRQ-1:0];
      if (take_go) begin
        dis_reg  <= 1'b1;
        insv_reg <= insv_reg | win_onehot;
        vec_reg  <= vec_calc;
      end else begin
        if (eret) dis_reg <= 1'b0;
        else if (cp0_we && cp0_addr == CP0_DIS) dis_reg <= cp0_wdata[0];
        if (eret_svc) insv_reg <= insv_after_eret;
      end
    end
  end

`ifdef CP0_NEST_EN
  localparam int SPW = $clog2(N_IRQ + 1);
  logic [31:0]    stack_reg [N_IRQ+1];
  logic [SPW-1:0] sp_reg, top_ptr;
  assign top_ptr = (sp_reg == '0) ? '0 : sp_reg - SPW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg <= '0;
      for (int i = 0; i <= N_IRQ; i++) stack_reg[i] <= '0;
    end else if (take_go) begin
      stack_reg[sp_reg] <= pc_resume;
      sp_reg            <= sp_reg + SPW'(1);
    end else begin
      if (cp0_we && cp0_addr == CP0_EPC) stack_reg[top_ptr] <= cp0_wdata;
      if (eret_svc && sp_reg != '0) sp_reg <= sp_reg - SPW'(1);
    end
  end

  assign epc = stack_reg[top_ptr];
`else
  logic [31:0] epc_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              epc_reg <= '0;
    else if (take_go)                        epc_reg <= pc_resume;
    else if (cp0_we && cp0_addr == CP0_EPC)  epc_reg <= cp0_wdata;
  end
  assign epc = epc_reg;
`endif

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_EPC:  cp0_rdata = epc;
      CP0_DIS:  cp0_rdata = {31'd0, dis_reg};
      CP0_MASK: cp0_rdata = 32'(mask_reg);
      CP0_PEND: cp0_rdata = 32'(pend_reg);
      CP0_INSV: cp0_rdata = 32'(insv_reg);
      default:  cp0_rdata = '0;
    endcase
  end

  assign take_irq   = (state_reg == TAKE);
  assign irq_vector = vec_reg;

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: scoreboard bench for cp0_intc; expected takes are queued when the
// interrupt stimulus is driven and checked by a monitor when take_irq fires.
module tb_cp0_intc;

  logic        clk, rst_n, stall, cp0_we, eret;
  logic [2:0]  irq_in;
  logic [31:0] pc_resume, cp0_wdata, cp0_rdata, irq_vector, epc;
  logic [4:0]  cp0_addr;
  logic        take_irq;

  typedef struct packed { logic [31:0] vec; logic [31:0] epc; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0, checks = 0;
  int cyc = 0, drv_cyc = 0, take_cnt = 0, take_cyc = 0;
  bit prev_take = 0;
  logic [31:0] d;

  cp0_intc #(.N_IRQ(3), .VEC_BASE(32'h0), .VEC_STRIDE(32'h200)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .stall(stall), .pc_resume(pc_resume),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .eret(eret),
    .cp0_rdata(cp0_rdata), .take_irq(take_irq), .irq_vector(irq_vector), .epc(epc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample 1 time unit after the active edge, pop scoreboard on each take.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && take_irq) begin
        take_cnt++;
        take_cyc = cyc;
        checks++;
        if (prev_take) begin
          errors++;
          $display("FAIL take_consecutive: take_irq=1 for a second cycle, required 0");
        end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL take_unexpected: take with vector=%h, required no take", irq_vector);
        end else begin
          e = exp_q.pop_front();
          $display("take: vector=%h epc=%h (expected vector=%h epc=%h)", irq_vector, epc, e.vec, e.epc);
          checks++;
          if (irq_vector !== e.vec) begin
            errors++;
            $display("FAIL take_vector: got %h, required %h", irq_vector, e.vec);
          end
          checks++;
          if (epc !== e.epc) begin
            errors++;
            $display("FAIL take_epc: got %h, required %h", epc, e.epc);
          end
        end
      end
      prev_take = rst_n && take_irq;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic rd(input logic [4:0] a, output logic [31:0] q);
    @(negedge clk);
    cp0_addr = a;
    #1;
    q = cp0_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    cp0_we = 1; cp0_addr = a; cp0_wdata = v;
    drv_cyc = cyc;
    @(negedge clk);
    cp0_we = 0;
  endtask

  task automatic pulse(input logic [2:0] bits);
    @(negedge clk);
    irq_in = bits;
    drv_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
    irq_in = 3'b000;
  endtask

  task automatic do_eret();
    @(negedge clk);
    eret = 1;
    @(negedge clk);
    eret = 0;
  endtask

  task automatic wait_take(input string name, input int n);
    int start;
    bit got;
    start = take_cnt;
    got = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (take_cnt != start) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no take within %0d cycles, required one", name, n);
    end
  endtask

  task automatic test_reset();
    checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL reset_take: got %b, required 0", take_irq); end
    checks++; if (irq_vector !== 32'h0) begin errors++; $display("FAIL reset_vector: got %h, required 0", irq_vector); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h, required 0", epc); end
    rd(5'h0e, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rd_epc: got %h, required 0", d); end
    rd(5'h16, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_rd_dis: got %h, required 1", d); end
    rd(5'h17, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rd_mask: got %h, required 0", d); end
    rd(5'h0d, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rd_pend: got %h, required 0", d); end
    rd(5'h18, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rd_insv: got %h, required 0", d); end
    wr(5'h01, 32'hffff_ffff);
    rd(5'h01, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h, required 0", d); end
  endtask

  task automatic test_basic();
    wr(5'h17, 32'h7);
    wr(5'h16, 32'h0);
    rd(5'h17, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL mask_rd: got %h, required 7", d); end
    pc_resume = 32'h0000_1000;
    exp_q.push_back('{vec: 32'h200, epc: 32'h1000});
    pulse(3'b010);
    wait_take("basic", 12);
    checks++;
    if (take_cyc - drv_cyc != 4) begin errors++; $display("FAIL basic_latency: got %0d cycles, required 4", take_cyc - drv_cyc); end
    rd(5'h18, d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_insv: got %h, required 2", d); end
    rd(5'h16, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_dis: got %h, required 1", d); end
    rd(5'h0d, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend: got %h, required 0", d); end
    rd(5'h0e, d); checks++; if (d !== 32'h1000) begin errors++; $display("FAIL basic_rd_epc: got %h, required 1000", d); end
    do_eret();
    rd(5'h16, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL eret_dis: got %h, required 0", d); end
    rd(5'h18, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL eret_insv: got %h, required 0", d); end
  endtask

  task automatic test_simultaneous();
    pc_resume = 32'h0000_2000;
    exp_q.push_back('{vec: 32'h0, epc: 32'h2000});
    exp_q.push_back('{vec: 32'h400, epc: 32'h2100});
    pulse(3'b101);
    wait_take("simul_first", 12);
    pc_resume = 32'h0000_2100;
    rd(5'h0d, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL simul_pend_mid: got %h, required 1", d); end
    do_eret();
    wait_take("simul_second", 8);
    rd(5'h0d, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL simul_pend_end: got %h, required 0", d); end
    do_eret();
  endtask

  task automatic test_w1c();
    wr(5'h17, 32'h0);
    pulse(3'b001);
    @(negedge clk);
    rd(5'h0d, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL w1c_pend_set: got %h, required 1", d); end
    wr(5'h0d, 32'h1);
    rd(5'h0d, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend_clr: got %h, required 0", d); end
  endtask

  task automatic test_mask();
    int start;
    wr(5'h17, 32'h3);
    start = take_cnt;
    pulse(3'b100);
    repeat (5) @(negedge clk);
    checks++; if (take_cnt != start) begin errors++; $display("FAIL mask_blocked: got %0d takes, required 0", take_cnt - start); end
    rd(5'h0d, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL mask_pend: got %h, required 4", d); end
    pc_resume = 32'h0000_3300;
    exp_q.push_back('{vec: 32'h0, epc: 32'h3300});
    wr(5'h17, 32'h7);
    wait_take("mask", 8);
    checks++;
    if (take_cyc - drv_cyc != 2) begin errors++; $display("FAIL mask_latency: got %0d cycles, required 2", take_cyc - drv_cyc); end
    do_eret();
  endtask

  task automatic test_stall();
    int start;
    @(negedge clk);
    stall = 1;
    start = take_cnt;
    pc_resume = 32'h0000_5000;
    exp_q.push_back('{vec: 32'h200, epc: 32'h5000});
    pulse(3'b010);
    repeat (6) @(negedge clk);
    checks++; if (take_cnt != start) begin errors++; $display("FAIL stall_blocked: got %0d takes, required 0", take_cnt - start); end
    stall = 0;
    drv_cyc = cyc;
    wait_take("stall", 6);
    checks++;
    if (take_cyc - drv_cyc != 1) begin errors++; $display("FAIL stall_latency: got %0d cycles, required 1", take_cyc - drv_cyc); end
    do_eret();
  endtask

  task automatic test_nest();
    int start;
    pc_resume = 32'h0000_3000;
    exp_q.push_back('{vec: 32'h400, epc: 32'h3000});
    pulse(3'b001);
    wait_take("nest_first", 12);
    pc_resume = 32'h0000_3100;
    start = take_cnt;
`ifdef CP0_NEST_EN
    exp_q.push_back('{vec: 32'h0, epc: 32'h3100});
    pulse(3'b100);
    wait_take("nest_inner", 12);
    rd(5'h18, d); checks++; if (d !== 32'h5) begin errors++; $display("FAIL nest_insv: got %h, required 5", d); end
    rd(5'h0e, d); checks++; if (d !== 32'h3100) begin errors++; $display("FAIL nest_epc_top: got %h, required 3100", d); end
    do_eret();
    checks++; if (epc !== 32'h3000) begin errors++; $display("FAIL nest_epc_pop: got %h, required 3000", epc); end
    rd(5'h18, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL nest_insv_pop: got %h, required 1", d); end
    do_eret();
    rd(5'h18, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL nest_insv_end: got %h, required 0", d); end
`else
    pulse(3'b100);
    repeat (5) @(negedge clk);
    checks++; if (take_cnt != start) begin errors++; $display("FAIL nest_blocked: got %0d takes, required 0", take_cnt - start); end
    rd(5'h0d, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL nest_pend: got %h, required 4", d); end
    exp_q.push_back('{vec: 32'h0, epc: 32'h3100});
    do_eret();
    wait_take("nest_after_eret", 8);
    do_eret();
`endif
  endtask

  task automatic test_reset_in_take();
    bit seen;
    seen = 0;
    pc_resume = 32'h0000_4000;
    exp_q.push_back('{vec: 32'h200, epc: 32'h4000});
    pulse(3'b010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (take_irq) begin
        seen = 1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_take_seen: take_irq never rose, required 1"); end
    rst_n = 0;
    #1;
    checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL rst_take_async: got %b, required 0", take_irq); end
    checks++; if (irq_vector !== 32'h0) begin errors++; $display("FAIL rst_vector: got %h, required 0", irq_vector); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc: got %h, required 0", epc); end
    rd(5'h16, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_dis: got %h, required 1", d); end
    rd(5'h17, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h, required 0", d); end
    rd(5'h18, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_insv: got %h, required 0", d); end
    rd(5'h0d, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pend: got %h, required 0", d); end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; stall = 0; cp0_we = 0; eret = 0; irq_in = 3'b000;
    pc_resume = 32'h0; cp0_wdata = 32'h0; cp0_addr = 5'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    repeat (2) @(negedge clk);
    test_basic();
    test_simultaneous();
    test_w1c();
    test_mask();
    test_stall();
    test_nest();
    test_reset_in_take();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected takes left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
